pixel_write_arbiter: RTL and testbench
======================================

Name: pixel_write_arbiter

Overview:
Shares the single VGA adapter pixel-write port (x, y, colour, plot) between independent sprite drawers: user, bullet, enemy field and future score/explosion drawers. Each drawer streams pixels over a valid/ready handshake grouped into bursts, one sprite per burst, terminated by a last flag. The arbiter grants whole bursts in round-robin order, clips off-screen pixels, and registers the adapter-side outputs. It sits between the sprite FSMs in the datapath and vga_adapter.

Parameters:
NUM_REQ, 4, number of requesters; index 0 = user, 1 = bullet, 2 = enemies, 3 = spare.
X_W, 9, x coordinate width.
Y_W, 8, y coordinate width.
C_W, 3, colour width.
X_MAX, 319, largest visible x.
Y_MAX, 239, largest visible y.
TIMEOUT, 1023, idle cycles allowed inside a burst before the grant is revoked.

Ports:
clk  in  1  system clock (CLOCK_50 domain).
resetn  in  1  asynchronous active-low reset.
req_valid  in  NUM_REQ  per-requester pixel valid.
req_last  in  NUM_REQ  per-requester final pixel of the burst; qualified by valid.
req_x  in  NUM_REQ*X_W  packed x; requester i occupies bits [i*X_W +: X_W].
req_y  in  NUM_REQ*Y_W  packed y.
req_colour  in  NUM_REQ*C_W  packed colour.
req_ready  out  NUM_REQ  per-requester ready; one-hot or zero.
vga_x  out  X_W  pixel x to the adapter.
vga_y  out  Y_W  pixel y to the adapter.
vga_colour  out  C_W  pixel colour to the adapter.
vga_plot  out  1  write strobe to the adapter.
grant_id  out  clog2(NUM_REQ)  current or most recent grantee.
busy  out  1  high in S_BURST.
timeout_pulse  out  1  one-cycle pulse when a grant is revoked by timeout.
clip_count  out  16  count of accepted pixels discarded as off-screen; saturates at 0xFFFF.

Behaviour:
- Reset (asynchronous, resetn=0):
  - State is S_IDLE.
  - req_ready, vga_plot, vga_x, vga_y, vga_colour, busy, timeout_pulse, clip_count are all 0.
  - grant_id = NUM_REQ-1, so requester 0 wins first.
  - Idle counter is 0.
- Reset mid-burst aborts the burst with no further plot. A requester must restart its burst after reset.
- S_IDLE:
  - req_ready = 0.
  - If any req_valid is high, the winner is the first set index searching from (grant_id+1) mod NUM_REQ upward with wrap.
  - grant_id <= winner; go to S_BURST.
  - With no valid, stay in S_IDLE.
- S_BURST:
  - req_ready[grant_id] = 1 combinationally; all other ready bits are 0.
  - A pixel is accepted when req_valid[grant_id] && req_ready[grant_id].
  - Accepting a pixel with req_last=1 moves to S_IDLE next cycle. This gives one dead cycle between bursts.
  - Non-granted requesters hold their valid and data stable; they are never dropped.
- Output stage, 1-cycle latency:
  - On an accepted pixel with x<=X_MAX and y<=Y_MAX, the next cycle drives vga_plot=1 and vga_x/vga_y/vga_colour = that pixel.
  - Off-screen accepted pixels produce vga_plot=0 and clip_count+1, saturating. They are still consumed, and their last flag still ends the burst.
  - In every cycle with no accepted pixel, vga_plot=0 and vga_x/vga_y/vga_colour hold their previous values.
- Timeout:
  - In S_BURST, the idle counter increments on each cycle where req_valid[grant_id]=0 and clears on every accepted pixel.
  - When the counter reaches TIMEOUT, in that same cycle: return to S_IDLE, pulse timeout_pulse, and clear the counter.
  - grant_id keeps the revoked index, so rotation advances past it.
  - The idle counter is 0 in S_IDLE.
- Simultaneous requests: round-robin rotation guarantees each active requester a burst within NUM_REQ grants.
- The same requester re-requesting immediately after its last pixel wins again only if no other requester is valid.
- Widths: coordinate comparisons are unsigned at full port width. Packed-slice selection uses grant_id.

Test Plan:
- Reset with all valid low -> vga_plot=0, req_ready=0, grant_id=3, clip_count=0. Assert resetn=0 mid-burst -> outputs clear immediately, with no clk edge needed.
- Req0 sends a 3-pixel burst (10,20), (11,20), (12,20) with colour 3'b010 and last on the third pixel -> req_ready[0] rises 1 cycle after valid. vga_plot pulses on 3 consecutive cycles, each 1 cycle after acceptance, with matching coordinates. busy falls after the third accept.
- Req0, 1 and 2 each assert valid at cycle 0, each with 2-pixel bursts -> bursts are granted in order 0, 1, 2 with one dead cycle between. Requester 1 data is held stable and plotted intact.
- Req1 holds valid continuously with back-to-back bursts while req2 is also valid -> grants alternate 1, 2, 1, 2.
- Req2 sends pixels (320,5) and (5,240) then (5,5) with last -> only (5,5) is plotted, clip_count=2.
- Req0 granted, sends 1 pixel without last, then drops valid for 1023 cycles -> timeout_pulse fires, state returns to S_IDLE, and req1 pending is granted next.

Source files
------------

// File: rtl/pixel_write_arbiter.sv
// pixel_write_arbiter: round-robin burst arbiter sharing the VGA pixel-write port,
// with off-screen clipping, an idle-timeout grant revocation and registered outputs.
module pixel_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int X_W = 9,
  parameter int Y_W = 8,
  parameter int C_W = 3,
  parameter int X_MAX = 319,
  parameter int Y_MAX = 239,
  parameter int TIMEOUT = 1023,
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ-1:0]     req_last,
  input  logic [NUM_REQ*X_W-1:0] req_x,
  input  logic [NUM_REQ*Y_W-1:0] req_y,
  input  logic [NUM_REQ*C_W-1:0] req_colour,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [X_W-1:0]         vga_x,
  output logic [Y_W-1:0]         vga_y,
  output logic [C_W-1:0]         vga_colour,
  output logic                   vga_plot,
  output logic [GW-1:0]          grant_id,
  output logic                   busy,
  output logic                   timeout_pulse,
  output logic [15:0]            clip_count
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic {S_IDLE, S_BURST} state_t;
  state_t state, state_next;
  logic [TW-1:0] idle_cnt, idle_next;
  logic [GW-1:0] winner, lo, hi;
  logic hi_found, any_valid;
  logic sel_valid, sel_last, accept, on_screen, expire;
  logic [X_W-1:0] sel_x;
  logic [Y_W-1:0] sel_y;
  logic [C_W-1:0] sel_colour;
  // Prefer the lowest valid index above the last grantee, else wrap to the lowest overall.
  always_comb begin
    lo = '0;
    hi = '0;
    hi_found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo = GW'(i);
        if (GW'(i) > grant_id) begin
          hi = GW'(i);
          hi_found = 1'b1;
        end
      end
    end
    any_valid = |req_valid;
    winner = hi_found ? hi : lo;
  end
  always_comb begin
    sel_valid = 1'b0;
    sel_last = 1'b0;
    sel_x = '0;
    sel_y = '0;
    sel_colour = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == GW'(i)) begin
        sel_valid = req_valid[i];
        sel_last = req_last[i];
        sel_x = req_x[i*X_W +: X_W];
        sel_y = req_y[i*Y_W +: Y_W];
        sel_colour = req_colour[i*C_W +: C_W];
      end
    end
  end
  assign busy = (state == S_BURST);
  assign req_ready = busy ? NUM_REQ'(1) << grant_id : '0;
  assign accept = busy && sel_valid;
  assign on_screen = (sel_x <= X_W'(X_MAX)) && (sel_y <= Y_W'(Y_MAX));
  assign expire = busy && !sel_valid && (idle_cnt == TW'(TIMEOUT - 1));
  always_comb begin
    state_next = state;
    idle_next = '0;
    if (state == S_IDLE) begin
      state_next = any_valid ? S_BURST : S_IDLE;
    end else begin
      state_next = ((accept && sel_last) || expire) ? S_IDLE : S_BURST;
      idle_next = (accept || expire) ? '0 : idle_cnt + TW'(1);
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      idle_cnt <= '0;
      grant_id <= GW'(NUM_REQ - 1);
      timeout_pulse <= 1'b0;
      vga_plot <= 1'b0;
      vga_x <= '0;
      vga_y <= '0;
      vga_colour <= '0;
      clip_count <= '0;
    end else begin
      state <= state_next;
      idle_cnt <= idle_next;
      timeout_pulse <= expire;
      vga_plot <= accept && on_screen;
      if (state == S_IDLE && any_valid) grant_id <= winner;
      if (accept && on_screen) begin
        vga_x <= sel_x;
        vga_y <= sel_y;
        vga_colour <= sel_colour;
      end
      if (accept && !on_screen && clip_count != 16'hFFFF) clip_count <= clip_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_pixel_write_arbiter.sv
// tb_pixel_write_arbiter: directed and randomized bursts checked every cycle against
// a transaction-driven reference model of the arbiter.
module tb_pixel_write_arbiter;
  localparam int N = 4, XW = 9, YW = 8, CW = 3, TO = 1023;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [N-1:0] req_valid = '0, req_last = '0;
  logic [N*XW-1:0] req_x = '0;
  logic [N*YW-1:0] req_y = '0;
  logic [N*CW-1:0] req_colour = '0;
  logic [N-1:0] req_ready;
  logic [XW-1:0] vga_x;
  logic [YW-1:0] vga_y;
  logic [CW-1:0] vga_colour;
  logic vga_plot, busy, timeout_pulse;
  logic [1:0] grant_id;
  logic [15:0] clip_count;
  pixel_write_arbiter dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_last(req_last),
    .req_x(req_x), .req_y(req_y), .req_colour(req_colour), .req_ready(req_ready),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .grant_id(grant_id), .busy(busy), .timeout_pulse(timeout_pulse), .clip_count(clip_count)
  );
  always #5 clk = ~clk;
  typedef struct {int x; int y; int c; bit last; int gap;} pix_t;
  pix_t q[N][$];
  int gap[N];
  int total = 0, bad = 0;
  bit m_busy, m_plot, m_to, acc, prev_busy;
  int m_gnt, m_idle, m_x, m_y, m_c, m_clip, ag, plots, tos;
  int glog[$];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += q[i].size();
    return s;
  endfunction
  task automatic push(input int r, input int x, input int y, input int c, input bit last, input int g);
    pix_t p;
    p.x = x; p.y = y; p.c = c; p.last = last; p.gap = g;
    q[r].push_back(p);
  endtask
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (q[i].size() > 0) && (gap[i] == 0);
      req_last[i] = 1'b0;
      if (q[i].size() > 0) begin
        req_last[i] = q[i][0].last;
        req_x[i*XW +: XW] = XW'(q[i][0].x);
        req_y[i*YW +: YW] = YW'(q[i][0].y);
        req_colour[i*CW +: CW] = CW'(q[i][0].c);
      end
    end
  endtask
  task automatic model_reset();
    m_busy = 0; m_gnt = N - 1; m_idle = 0; m_plot = 0; m_to = 0;
    m_x = 0; m_y = 0; m_c = 0; m_clip = 0; prev_busy = 0;
  endtask
  task automatic step();
    drive();
    @(negedge clk);
    chk("ready", 32'(req_ready), m_busy ? (1 << m_gnt) : 0);
    chk("busy", 32'(busy), 32'(m_busy));
    chk("grant", 32'(grant_id), m_gnt);
    chk("plot", 32'(vga_plot), 32'(m_plot));
    chk("vga_x", 32'(vga_x), m_x);
    chk("vga_y", 32'(vga_y), m_y);
    chk("colour", 32'(vga_colour), m_c);
    chk("timeout", 32'(timeout_pulse), 32'(m_to));
    chk("clip", 32'(clip_count), m_clip);
    if (busy && !prev_busy) glog.push_back(int'(grant_id));
    prev_busy = busy;
    plots += int'(vga_plot);
    tos += int'(timeout_pulse);
    acc = m_busy && req_valid[m_gnt];
    ag = m_gnt;
    m_plot = 0;
    m_to = 0;
    if (acc) begin
      if (q[ag][0].x <= 319 && q[ag][0].y <= 239) begin
        m_plot = 1; m_x = q[ag][0].x; m_y = q[ag][0].y; m_c = q[ag][0].c;
      end else if (m_clip < 65535) m_clip++;
      m_idle = 0;
      if (q[ag][0].last) m_busy = 0;
    end else if (m_busy) begin
      m_idle++;
      if (m_idle == TO) begin m_busy = 0; m_idle = 0; m_to = 1; end
    end else if (req_valid != 0) begin
      for (int k = 1; k <= N; k++) begin
        if (req_valid[(m_gnt + k) % N]) begin m_gnt = (m_gnt + k) % N; break; end
      end
      m_busy = 1;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (gap[i] > 0) gap[i]--;
    if (acc) begin
      gap[ag] = q[ag][0].gap;
      void'(q[ag].pop_front());
    end
  endtask
  task automatic run(input int maxc);
    int n = 0;
    while (pending() > 0 && n < maxc) begin step(); n++; end
    chk("drain", pending(), 0);
    repeat (3) step();
  endtask
  task automatic do_reset();
    resetn = 1'b0;
    for (int i = 0; i < N; i++) begin q[i].delete(); gap[i] = 0; end
    drive();
    @(posedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_plot", 32'(vga_plot), 0);
    chk("rst_grant", 32'(grant_id), 3);
    chk("rst_clip", 32'(clip_count), 0);
    model_reset();
    @(posedge clk);
    #1 resetn = 1'b1;
  endtask
  initial begin
    do_reset();
    plots = 0;
    push(0, 10, 20, 2, 0, 0); push(0, 11, 20, 2, 0, 0); push(0, 12, 20, 2, 1, 0);
    run(50);
    chk("t2_plots", plots, 3);
    push(0, 1, 2, 5, 0, 0); push(0, 2, 2, 5, 0, 0); push(0, 3, 2, 5, 1, 0);
    repeat (3) step();
    resetn = 1'b0;
    #1;
    chk("async_ready", 32'(req_ready), 0);
    chk("async_busy", 32'(busy), 0);
    chk("async_plot", 32'(vga_plot), 0);
    chk("async_grant", 32'(grant_id), 3);
    do_reset();
    glog.delete();
    for (int r = 0; r < 3; r++) begin
      push(r, 20 + r, 30, r, 0, 0);
      push(r, 40 + r, 31, r + 4, 1, 0);
    end
    run(100);
    chk("t3_n", glog.size(), 3);
    for (int i = 0; i < 3; i++) chk("t3_order", glog[i], i);
    glog.delete();
    for (int b = 0; b < 2; b++) begin
      push(1, 100 + b, 50, 1, 0, 0); push(1, 110 + b, 50, 1, 1, 0);
      push(2, 200 + b, 60, 6, 0, 0); push(2, 210 + b, 60, 6, 1, 0);
    end
    run(100);
    chk("t4_n", glog.size(), 4);
    for (int i = 0; i < 4; i++) chk("t4_order", glog[i], (i % 2 == 0) ? 1 : 2);
    do_reset();
    plots = 0;
    push(2, 320, 5, 7, 0, 0); push(2, 5, 240, 7, 0, 0); push(2, 5, 5, 7, 1, 0);
    run(50);
    chk("t5_clip", 32'(clip_count), 2);
    chk("t5_plots", plots, 1);
    chk("t5_x", 32'(vga_x), 5);
    chk("t5_y", 32'(vga_y), 5);
    do_reset();
    glog.delete();
    tos = 0;
    push(0, 7, 7, 3, 0, 0);
    push(1, 8, 8, 4, 0, 0); push(1, 9, 8, 4, 1, 0);
    run(3000);
    chk("t6_tos", tos, 1);
    chk("t6_n", glog.size(), 2);
    if (glog.size() == 2) begin
      chk("t6_first", glog[0], 0);
      chk("t6_next", glog[1], 1);
    end
    for (int r = 0; r < N; r++) begin
      int nb = $urandom_range(3, 6);
      for (int b = 0; b < nb; b++) begin
        int len = $urandom_range(1, 4);
        for (int p = 0; p < len; p++)
          push(r, $urandom_range(0, 340), $urandom_range(0, 255), $urandom_range(0, 7),
               p == len - 1, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
      end
    end
    run(20000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
